// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction fetch stage
//
// Issues single-outstanding fetch requests to the instruction memory and
// hands fetched instructions to ID through a registered IF/ID output set.
// A one-entry buffer absorbs a response that arrives while ID is stalled.
// Redirects from EX squash whatever is in flight; a halt request stops
// fetching permanently until reset.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   stall_F               hold the IF/ID outputs (hazard unit)
//   redirect_valid/_pc    taken branch/jump target resolved in EX
//   halt_in               halt request, sticky once sampled
//   imem_req/_addr        fetch request and word-aligned address
//   imem_gnt              request accepted this cycle
//   imem_rvalid/_rdata    fetch response (arrives >= 1 cycle after grant)
//   f_inst/f_pc_current   instruction and its PC to ID (registered)
//   f_valid               f_inst is a real instruction
//   halted                fetch permanently stopped
// -----------------------------------------------------------------------------
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_F,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt_in,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] f_inst,
   output logic [31:0] f_pc_current,
   output logic        f_valid,
   output logic        halted
);

   typedef enum logic [2:0] {
      S_REQ    = 3'd0,
      S_WAIT   = 3'd1,
      S_HOLD   = 3'd2,
      S_DROP   = 3'd3,
      S_HALTED = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;             // next fetch address
   logic [31:0] req_pc_q, req_pc_d;     // address of the request in flight
   logic [31:0] buf_inst_q, buf_inst_d; // one-entry stall buffer (valid in HOLD)
   logic        halt_q, halt_d;         // sticky halt request
   logic [31:0] f_inst_q, f_inst_d;
   logic [31:0] f_pc_q, f_pc_d;
   logic        f_valid_q, f_valid_d;

   logic        halt_now;
   logic [31:0] req_pc_plus4;

   // A halt request takes effect in the very cycle it is seen, so a request
   // is never raised alongside it.
   assign halt_now     = halt_q | halt_in;
   assign req_pc_plus4 = req_pc_q + 32'd4;   // wraps naturally modulo 2^32

   assign imem_req     = (state_q == S_REQ) && !halt_now && !rst;
   assign imem_addr    = pc_q;
   assign halted       = (state_q == S_HALTED);
   assign f_inst       = f_inst_q;
   assign f_pc_current = f_pc_q;
   assign f_valid      = f_valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         req_pc_q   <= 32'h0000_0000;
         buf_inst_q <= NOP_INST;
         halt_q     <= 1'b0;
         f_inst_q   <= NOP_INST;
         f_pc_q     <= 32'h0000_0000;
         f_valid_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         buf_inst_q <= buf_inst_d;
         halt_q     <= halt_d;
         f_inst_q   <= f_inst_d;
         f_pc_q     <= f_pc_d;
         f_valid_q  <= f_valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      buf_inst_d = buf_inst_q;
      halt_d     = halt_now;
      f_inst_d   = f_inst_q;
      f_pc_d     = f_pc_q;
      f_valid_d  = f_valid_q;

      // Outputs hold under stall, otherwise default to a bubble; a delivery
      // below overrides the bubble.
      if (!stall_F) begin
         f_inst_d  = NOP_INST;
         f_pc_d    = 32'h0000_0000;
         f_valid_d = 1'b0;
      end

      case (state_q)
         S_REQ: begin
            if (halt_now) begin
               state_d = S_HALTED;       // nothing outstanding in REQ
            end else if (imem_gnt) begin
               req_pc_d = pc_q;
               // a redirect in the grant cycle makes the new request stale
               state_d  = redirect_valid ? S_DROP : S_WAIT;
            end
         end

         S_WAIT: begin
            if (halt_now) begin
               state_d = imem_rvalid ? S_HALTED : S_DROP;
            end else if (redirect_valid) begin
               state_d = imem_rvalid ? S_REQ : S_DROP;
            end else if (imem_rvalid) begin
               if (!stall_F) begin
                  f_inst_d  = imem_rdata;
                  f_pc_d    = req_pc_q;
                  f_valid_d = 1'b1;
                  pc_d      = req_pc_plus4;
                  state_d   = S_REQ;
               end else begin
                  buf_inst_d = imem_rdata;  // req_pc_q keeps its PC
                  state_d    = S_HOLD;
               end
            end
         end

         S_HOLD: begin
            if (halt_now) begin
               state_d = S_HALTED;       // buffered instruction is discarded
            end else if (redirect_valid) begin
               state_d = S_REQ;
            end else if (!stall_F) begin
               f_inst_d  = buf_inst_q;
               f_pc_d    = req_pc_q;
               f_valid_d = 1'b1;
               pc_d      = req_pc_plus4;
               state_d   = S_REQ;
            end
         end

         S_DROP: begin
            // The stale response is swallowed; a further redirect here only
            // updates pc, the single outstanding response is still pending.
            if (imem_rvalid) begin
               state_d = halt_now ? S_HALTED : S_REQ;
            end
         end

         S_HALTED: begin
            halt_d = 1'b1;
         end

         default: begin
            state_d = S_REQ;
         end
      endcase

      // Redirect beats stall and delivery, but loses to halt.
      if (redirect_valid && !halt_now) begin
         pc_d       = {redirect_pc[31:2], 2'b00};
         buf_inst_d = NOP_INST;
         f_inst_d   = NOP_INST;
         f_pc_d     = 32'h0000_0000;
         f_valid_d  = 1'b0;
      end

      if (state_q == S_HALTED) begin
         f_inst_d  = NOP_INST;
         f_pc_d    = 32'h0000_0000;
         f_valid_d = 1'b0;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage -- directed bench for if_stage.
// Expected deliveries are queued when a response is driven and popped when
// the stage presents a new valid instruction. A second instance with
// RESET_PC = 32'hFFFF_FFFC covers PC wrap-around.
// -----------------------------------------------------------------------------
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        stall_F = 1'b0, redirect_valid = 1'b0, halt_in = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
   logic [31:0] imem_addr, imem_rdata = '0;
   logic [31:0] f_inst, f_pc_current;
   logic        f_valid, halted;

   logic        b_req, b_rvalid = 1'b0, b_valid, b_halted;
   logic [31:0] b_addr, b_inst, b_pc;

   if_stage dut (
      .clk(clk), .rst(rst), .stall_F(stall_F),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halt_in(halt_in), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .f_inst(f_inst), .f_pc_current(f_pc_current), .f_valid(f_valid),
      .halted(halted)
   );

   if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst(rst), .stall_F(1'b0),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .halt_in(1'b0), .imem_req(b_req), .imem_addr(b_addr),
      .imem_gnt(1'b1), .imem_rvalid(b_rvalid), .imem_rdata(32'h0000_0093),
      .f_inst(b_inst), .f_pc_current(b_pc), .f_valid(b_valid),
      .halted(b_halted)
   );

   typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
   exp_t        sb[$];

   int          n_cmp = 0;
   int          n_err = 0;
   logic        auto_mem = 1'b0;
   logic [31:0] exp_pc = '0;
   logic [31:0] hold_inst = NOP, hold_pc = '0;
   logic        hold_valid = 1'b0;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h0013_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Checks the IF/ID outputs just after an edge, given the stall/redirect
   // the bench drove into that edge.
   task automatic monitor(input logic stall_e, input logic redir_e);
      exp_t e;
      if (redir_e || !stall_e) begin
         if (f_valid && !redir_e) begin
            if (sb.size() == 0) begin
               chk1("unexpected_valid", f_valid, 1'b0);
            end else begin
               e = sb.pop_front();
               chk("deliver_pc", f_pc_current, e.pc);
               chk("deliver_inst", f_inst, e.inst);
               $display("deliver pc=%h inst=%h", f_pc_current, f_inst);
               hold_inst = e.inst; hold_pc = e.pc; hold_valid = 1'b1;
            end
         end else begin
            chk1("bubble_valid", f_valid, 1'b0);
            chk("bubble_inst", f_inst, NOP);
            chk("bubble_pc", f_pc_current, 32'h0);
            hold_inst = NOP; hold_pc = '0; hold_valid = 1'b0;
         end
      end else begin
         chk1("hold_valid", f_valid, hold_valid);
         chk("hold_inst", f_inst, hold_inst);
         chk("hold_pc", f_pc_current, hold_pc);
      end
   endtask

   task automatic cyc();
      logic        granted, b_gr, stall_e, redir_e;
      logic [31:0] gaddr;
      granted = imem_req & imem_gnt;
      gaddr   = imem_addr;
      stall_e = stall_F;
      redir_e = redirect_valid;
      b_gr    = b_req;
      if (auto_mem && granted) begin
         chk("fetch_addr", imem_addr, exp_pc);
         sb.push_back('{exp_pc, memf(exp_pc)});
         exp_pc = exp_pc + 32'd4;
      end
      @(posedge clk);
      #1;
      b_rvalid = b_gr;
      if (auto_mem) begin
         imem_rvalid = granted;
         imem_rdata  = memf(gaddr);
      end
      monitor(stall_e, redir_e);
   endtask

   task automatic do_reset();
      chk("sb_empty_before_reset", 32'(sb.size()), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      stall_F = 1'b0; redirect_valid = 1'b0; halt_in = 1'b0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; auto_mem = 1'b0; b_rvalid = 1'b0;
      #1;
      chk1("rst_req", imem_req, 1'b0);
      chk1("rst_valid", f_valid, 1'b0);
      chk("rst_inst", f_inst, NOP);
      chk("rst_pc", f_pc_current, 32'h0);
      chk1("rst_halted", halted, 1'b0);
      @(posedge clk);
      #1;
      chk1("rst_req_clocked", imem_req, 1'b0);
      chk1("rst_b_req", b_req, 1'b0);
      rst = 1'b0;
      hold_inst = NOP; hold_pc = '0; hold_valid = 1'b0;
      #1;
      chk1("post_rst_req", imem_req, 1'b1);
      chk("post_rst_addr", imem_addr, 32'h0);
      $display("reset released");
   endtask

   initial begin
      // ---- zero-wait memory, no stall
      do_reset();
      chk("wrap_first_addr", b_addr, 32'hFFFF_FFFC);
      exp_pc = 32'h0; auto_mem = 1'b1; imem_gnt = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         cyc();
         chk1("valid_cadence", f_valid, (k % 2) == 0);
         if (k == 2) begin
            chk("wrap_second_addr", b_addr, 32'h0000_0000);
            chk("wrap_f_pc", b_pc, 32'hFFFF_FFFC);
            chk1("wrap_f_valid", b_valid, 1'b1);
         end
      end

      // ---- stall while the response arrives
      auto_mem = 1'b0; imem_rvalid = 1'b0;
      stall_F = 1'b1; imem_gnt = 1'b1;
      chk("stall_fetch_addr", imem_addr, 32'd20);
      cyc();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
      sb.push_back('{32'd20, 32'h0050_0093});
      cyc();
      imem_rvalid = 1'b0;
      chk1("hold_no_req1", imem_req, 1'b0);
      cyc();
      chk1("hold_no_req2", imem_req, 1'b0);
      cyc();
      stall_F = 1'b0;
      cyc();
      chk1("no_refetch_req", imem_req, 1'b1);
      chk("no_refetch_addr", imem_addr, 32'd24);
      chk("stall_sb_empty", 32'(sb.size()), 32'h0);

      // ---- redirect while waiting: stale response dropped
      imem_gnt = 1'b1;
      cyc();
      imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
      cyc();
      redirect_valid = 1'b0;
      chk1("drop_no_req", imem_req, 1'b0);
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      cyc();
      imem_rvalid = 1'b0;
      chk1("redir_req", imem_req, 1'b1);
      chk("redir_addr", imem_addr, 32'h100);

      // ---- redirect under stall from HOLD, unaligned target
      imem_gnt = 1'b1;
      cyc();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
      sb.push_back('{32'h100, 32'h00A0_0113});
      cyc();
      imem_rvalid = 1'b0; stall_F = 1'b1; imem_gnt = 1'b1;
      cyc();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
      cyc();
      imem_rvalid = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h102;
      cyc();
      redirect_valid = 1'b0; stall_F = 1'b0;
      chk1("align_req", imem_req, 1'b1);
      chk("align_addr", imem_addr, 32'h100);
      cyc();
      chk("align_addr_kept", imem_addr, 32'h100);

      // ---- redirect in the grant cycle
      imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
      cyc();
      redirect_valid = 1'b0; imem_gnt = 1'b0;
      chk1("gnt_redir_no_req", imem_req, 1'b0);
      imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
      cyc();
      imem_rvalid = 1'b0;
      chk("gnt_redir_addr", imem_addr, 32'h200);

      // ---- halt while waiting
      imem_gnt = 1'b1;
      cyc();
      imem_gnt = 1'b0; halt_in = 1'b1;
      cyc();
      halt_in = 1'b0;
      chk1("halt_pend_no_req", imem_req, 1'b0);
      chk1("halt_pend_not_halted", halted, 1'b0);
      imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
      cyc();
      imem_rvalid = 1'b0; imem_gnt = 1'b1; redirect_pc = 32'h400;
      for (int i = 0; i < 20; i++) begin
         redirect_valid = i[0];
         cyc();
         chk1("halted_no_req", imem_req, 1'b0);
         chk1("halted_flag", halted, 1'b1);
      end
      redirect_valid = 1'b0; imem_gnt = 1'b0;

      // ---- reset restores fetch; stale response after reset is ignored
      do_reset();
      imem_rvalid = 1'b1; imem_rdata = 32'h4444_4444;
      cyc();
      imem_rvalid = 1'b0;
      chk1("stale_post_rst_req", imem_req, 1'b1);
      chk("stale_post_rst_addr", imem_addr, 32'h0);

      // ---- halt and redirect together: halt wins
      halt_in = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300; imem_gnt = 1'b1;
      cyc();
      halt_in = 1'b0; redirect_valid = 1'b0; imem_gnt = 1'b0;
      chk1("halt_wins_halted", halted, 1'b1);
      chk1("halt_wins_no_req", imem_req, 1'b0);
      chk("halt_wins_pc", imem_addr, 32'h0);
      cyc();

      chk("final_sb_empty", 32'(sb.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
